// File: rtl/calendar_date_counter.sv
// Registered calendar date (day/month/year) advanced one day per day_tick,
// with validated date loading and Gregorian leap-year tracking.
module calendar_date_counter #(
  parameter int unsigned RESET_YEAR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        day_tick,
  input  logic        load,
  input  logic [5:0]  load_day,
  input  logic [3:0]  load_month,
  input  logic [10:0] load_year,
  output logic [5:0]  day_of_month,
  output logic [3:0]  month,
  output logic [10:0] year,
  output logic        leap_year,
  output logic        date_changed,
  output logic        year_wrap,
  output logic        load_err
);

  localparam logic [10:0] RESET_YEAR_V = RESET_YEAR[10:0];
  localparam logic [10:0] MAX_YEAR     = 11'd2047;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_ADVANCE
  } op_e;

  function automatic logic is_leap(input logic [10:0] y);
    return ((y % 11'd400) == 11'd0) ||
           (((y % 11'd100) != 11'd0) && (y[1:0] == 2'b00));
  endfunction

  function automatic logic [5:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 6'd30;
      default:                   return 6'd31;
    endcase
  endfunction

  op_e         op;
  logic        load_valid;
  logic [5:0]  next_day;
  logic [3:0]  next_month;
  logic [10:0] next_year;
  logic        next_leap;
  logic        next_changed;
  logic        next_wrap;
  logic        next_err;

  always_comb begin
    if (load)          op = OP_LOAD;
    else if (day_tick) op = OP_ADVANCE;
    else               op = OP_HOLD;
  end

  // A load is accepted only if it names a real date; the registers never hold an illegal one.
  always_comb begin
    load_valid = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                 (load_year != 11'd0) && (load_day != 6'd0) &&
                 (load_day <= days_in_month(load_month, is_leap(load_year)));
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_day     = day_of_month;
    next_month   = month;
    next_year    = year;
    next_changed = 1'b0;
    next_wrap    = 1'b0;
    next_err     = 1'b0;

    case (op)
      OP_LOAD: begin
        if (load_valid) begin
          next_day     = load_day;
          next_month   = load_month;
          next_year    = load_year;
          next_changed = 1'b1;
        end else begin
          next_err = 1'b1;
        end
      end
      OP_ADVANCE: begin
        next_changed = 1'b1;
        if (day_of_month < days_in_month(month, leap_year)) begin
          next_day = day_of_month + 6'd1;
        end else begin
          next_day = 6'd1;
          if (month < 4'd12) begin
            next_month = month + 4'd1;
          end else begin
            next_month = 4'd1;
            if (year < MAX_YEAR) begin
              next_year = year + 11'd1;
            end else begin
              next_year = 11'd1;
              next_wrap = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    // Derived from the year being written so leap_year is never a cycle stale.
    next_leap = is_leap(next_year);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_of_month <= 6'd1;
      month        <= 4'd1;
      year         <= RESET_YEAR_V;
      leap_year    <= is_leap(RESET_YEAR_V);
      date_changed <= 1'b0;
      year_wrap    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      day_of_month <= next_day;
      month        <= next_month;
      year         <= next_year;
      leap_year    <= next_leap;
      date_changed <= next_changed;
      year_wrap    <= next_wrap;
      load_err     <= next_err;
    end
  end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed self-checking bench for calendar_date_counter: reset, leap rule,
// year wrap, invalid loads, load/tick priority and full-year runs.
module tb_calendar_date_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        day_tick;
  logic        load;
  logic [5:0]  load_day;
  logic [3:0]  load_month;
  logic [10:0] load_year;
  logic [5:0]  day_of_month;
  logic [3:0]  month;
  logic [10:0] year;
  logic        leap_year;
  logic        date_changed;
  logic        year_wrap;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  calendar_date_counter #(.RESET_YEAR(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .day_tick     (day_tick),
    .load         (load),
    .load_day     (load_day),
    .load_month   (load_month),
    .load_year    (load_year),
    .day_of_month (day_of_month),
    .month        (month),
    .year         (year),
    .leap_year    (leap_year),
    .date_changed (date_changed),
    .year_wrap    (year_wrap),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pack_date(input int d, input int m, input int y);
    logic [5:0]  dd;
    logic [3:0]  mm;
    logic [10:0] yy;
    dd = d[5:0];
    mm = m[3:0];
    yy = y[10:0];
    return {dd, mm, yy};
  endfunction

  // Downstream day-of-year as the calculator would derive it from the outputs.
  function automatic int day_of_year(input int d, input int m, input int y);
    int cum;
    logic lp;
    lp = ((y % 400) == 0) || (((y % 100) != 0) && ((y % 4) == 0));
    case (m)
      1: cum = 0;    2: cum = 31;   3: cum = 59;   4: cum = 90;
      5: cum = 120;  6: cum = 151;  7: cum = 181;  8: cum = 212;
      9: cum = 243;  10: cum = 273; 11: cum = 304; default: cum = 334;
    endcase
    if (lp && m > 2) cum = cum + 1;
    return cum + d;
  endfunction

  task automatic do_load(input int d, input int m, input int y, input logic with_tick);
    @(negedge clk);
    load       = 1'b1;
    day_tick   = with_tick;
    load_day   = d[5:0];
    load_month = m[3:0];
    load_year  = y[10:0];
    @(posedge clk);
    #1;
    load     = 1'b0;
    day_tick = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    day_tick = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    repeat (2) @(posedge clk);
    #1;
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(1, 1, 1) || leap_year !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: date=%h leap=%b, expected %h leap=0", got, leap_year, pack_date(1, 1, 1));
    end
    checks++;
    if ({date_changed, year_wrap, load_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 000", {date_changed, year_wrap, load_err});
    end
    @(negedge clk);
    rst = 1'b0;
    do_load(15, 6, 2020, 1'b0);
    @(negedge clk);
    day_tick = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(1, 1, 1) || leap_year !== 1'b0 ||
        {date_changed, year_wrap, load_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_midcount: date=%h leap=%b pulses=%b, expected %h leap=0 pulses=000",
               got, leap_year, {date_changed, year_wrap, load_err}, pack_date(1, 1, 1));
    end
    day_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_tick();
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(2, 1, 1) || date_changed !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_tick: date=%h chg=%b, expected %h chg=1", got, date_changed, pack_date(2, 1, 1));
    end
  endtask

  task automatic test_leap_rule();
    int ld_d[7]  = '{28, 28, 29, 28, 28, 28, 28};
    int ld_m[7]  = '{2, 2, 2, 2, 2, 2, 2};
    int ld_y[7]  = '{2019, 2020, 2020, 1900, 2000, 1600, 1700};
    int ticks[7] = '{1, 2, 1, 1, 1, 1, 1};
    int ex_d[7]  = '{1, 1, 1, 1, 29, 29, 1};
    int ex_m[7]  = '{3, 3, 3, 3, 2, 2, 3};
    logic ex_l[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [20:0] got;
    for (int i = 0; i < 7; i++) begin
      do_load(ld_d[i], ld_m[i], ld_y[i], 1'b0);
      checks++;
      if (leap_year !== ex_l[i] || date_changed !== 1'b1) begin
        errors++;
        $display("FAIL leap_after_load[%0d]: leap=%b chg=%b, expected leap=%b chg=1", i, leap_year, date_changed, ex_l[i]);
      end
      for (int t = 0; t < ticks[i]; t++) begin
        do_tick();
        if (i == 1 && t == 0) begin
          got = {day_of_month, month, year};
          checks++;
          if (got !== pack_date(29, 2, 2020)) begin
            errors++;
            $display("FAIL leap_2020_feb29: got %h expected %h", got, pack_date(29, 2, 2020));
          end
        end
      end
      got = {day_of_month, month, year};
      checks++;
      if (got !== pack_date(ex_d[i], ex_m[i], ld_y[i]) || leap_year !== ex_l[i] || date_changed !== 1'b1) begin
        errors++;
        $display("FAIL leap_tick[%0d]: date=%h leap=%b chg=%b, expected %h leap=%b chg=1",
                 i, got, leap_year, date_changed, pack_date(ex_d[i], ex_m[i], ld_y[i]), ex_l[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [20:0] got;
    do_load(31, 12, 2047, 1'b0);
    do_tick();
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(1, 1, 1) || year_wrap !== 1'b1 || leap_year !== 1'b0) begin
      errors++;
      $display("FAIL wrap_2047: date=%h wrap=%b leap=%b, expected %h wrap=1 leap=0", got, year_wrap, leap_year, pack_date(1, 1, 1));
    end
    @(posedge clk);
    #1;
    checks++;
    if (year_wrap !== 1'b0 || date_changed !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse_width: wrap=%b chg=%b, expected 0 0", year_wrap, date_changed);
    end
    do_load(31, 12, 2046, 1'b0);
    do_tick();
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(1, 1, 2047) || year_wrap !== 1'b0 || leap_year !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap_2046: date=%h wrap=%b leap=%b, expected %h wrap=0 leap=0", got, year_wrap, leap_year, pack_date(1, 1, 2047));
    end
  endtask

  task automatic test_invalid_load();
    int bd[7] = '{29, 31, 10, 10, 0, 1, 32};
    int bm[7] = '{2, 4, 0, 13, 3, 1, 1};
    int by[7] = '{2019, 2020, 2020, 2020, 2020, 0, 2020};
    logic [20:0] got;
    do_load(10, 5, 2021, 1'b0);
    for (int i = 0; i < 7; i++) begin
      do_load(bd[i], bm[i], by[i], i == 6);
      got = {day_of_month, month, year};
      checks++;
      if (got !== pack_date(10, 5, 2021) || load_err !== 1'b1 || date_changed !== 1'b0) begin
        errors++;
        $display("FAIL invalid_load[%0d]: date=%h err=%b chg=%b, expected %h err=1 chg=0",
                 i, got, load_err, date_changed, pack_date(10, 5, 2021));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_width: got %b expected 0", load_err);
    end
  endtask

  task automatic test_priority();
    logic [20:0] got;
    do_load(15, 6, 2020, 1'b1);
    got = {day_of_month, month, year};
    checks++;
    if (got !== pack_date(15, 6, 2020) || date_changed !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_over_tick: date=%h chg=%b err=%b, expected %h chg=1 err=0",
               got, date_changed, load_err, pack_date(15, 6, 2020));
    end
  endtask

  task automatic test_back_to_back();
    int yrs[2]  = '{2021, 2024};
    int n[2]    = '{364, 365};
    int exdoy[2] = '{365, 366};
    logic [20:0] got;
    int doy;
    for (int i = 0; i < 2; i++) begin
      do_load(1, 1, yrs[i], 1'b0);
      @(negedge clk);
      day_tick = 1'b1;
      repeat (n[i]) @(posedge clk);
      #1;
      day_tick = 1'b0;
      got = {day_of_month, month, year};
      doy = day_of_year(int'(day_of_month), int'(month), int'(year));
      checks++;
      if (got !== pack_date(31, 12, yrs[i]) || doy != exdoy[i]) begin
        errors++;
        $display("FAIL full_year[%0d]: date=%h doy=%0d, expected %h doy=%0d",
                 i, got, doy, pack_date(31, 12, yrs[i]), exdoy[i]);
      end
      @(posedge clk);
      #1;
      got = {day_of_month, month, year};
      checks++;
      if (got !== pack_date(31, 12, yrs[i]) || date_changed !== 1'b0) begin
        errors++;
        $display("FAIL hold_after_run[%0d]: date=%h chg=%b, expected %h chg=0", i, got, date_changed, pack_date(31, 12, yrs[i]));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    day_tick   = 1'b0;
    load       = 1'b0;
    load_day   = '0;
    load_month = '0;
    load_year  = '0;
    test_reset();
    test_leap_rule();
    test_wrap();
    test_invalid_load();
    test_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calendar_date_counter.md
# calendar_date_counter

Sequential date generator that sits directly upstream of the day-of-year calculator. It holds the current calendar date (day of month, month, year) and advances it by one day per `day_tick`, handling month lengths, Gregorian leap years and year wrap. Its registered date outputs connect straight to the calculator's `day_of_month`, `month` and `year` inputs. It also supports loading an arbitrary date, with validation of the loaded value.

## Interface
Parameters:
- `RESET_YEAR`, default 1: year value after reset; legal range 1..2047.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `day_tick`  in  1  advance the date by one day; sampled each cycle.
- `load`  in  1  load request, qualified by the three `load_*` fields.
- `load_day`  in  6  day of month to load, 1..31.
- `load_month`  in  4  month to load, 1..12.
- `load_year`  in  11  year to load, 1..2047.
- `day_of_month`  out  6  current day, 1..31.
- `month`  out  4  current month, 1..12.
- `year`  out  11  current year, 1..2047.
- `leap_year`  out  1  current year is a leap year; registered.
- `date_changed`  out  1  one-cycle pulse whenever the date registers were written.
- `year_wrap`  out  1  one-cycle pulse on the 2047-12-31 → 0001-01-01 rollover.
- `load_err`  out  1  one-cycle pulse when a load was rejected.

## Operation
- Reset values:
  - `day_of_month`=1, `month`=1, `year`=`RESET_YEAR`.
  - `leap_year`=leap(`RESET_YEAR`).
  - `date_changed`, `year_wrap` and `load_err` all = 0.
- Leap rule: leap(y) = (y%400==0) | (y%100!=0 & y%4==0).
- Days in month (dim):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Month 2: 29 if leap, else 28.
- Control states, evaluated every cycle in priority order:
  - **LOAD** (`load`=1): validate the load fields.
    - Valid means `load_month` in 1..12, `load_year` in 1..2047, and `load_day` in 1..dim(`load_month`, leap(`load_year`)).
    - If valid: write all three fields, set `leap_year`=leap(`load_year`), pulse `date_changed`.
    - If invalid: keep state, pulse `load_err`, no `date_changed`.
    - `day_tick` in the same cycle is dropped.
  - **ADVANCE** (`day_tick`=1, `load`=0):
    - If `day_of_month` < dim: day+1.
    - Otherwise day=1, then:
      - If `month` < 12: month+1.
      - Otherwise month=1, then:
        - If `year` < 2047: year+1.
        - Otherwise year=1 and pulse `year_wrap`.
    - In all cases pulse `date_changed`.
  - **HOLD**: otherwise; no change, all pulses 0.
- `leap_year` is recomputed from the next year value in the same edge that writes `year`. It is never one cycle stale.
- The leap computation must be exact for all 11-bit years: 2000 and 1600 are leap; 1900, 1800 and 1700 are not.
- State registers only ever hold valid dates; no illegal date is reachable.

## Timing
- Latency: a `day_tick` or `load` sampled at edge N updates outputs immediately after edge N. `date_changed`, `year_wrap` and `load_err` are high for exactly the cycle following edge N.
- Back-to-back ticks on consecutive cycles advance one day per cycle; no throughput limit.
- Downstream sampling: the day-of-year result is valid combinationally in the cycle `date_changed` is high.
- Simultaneous `load` and `day_tick`: load wins, including when the load is invalid (the tick is still dropped).
- Reset asserted mid-operation forces the reset values asynchronously. Pulses clear immediately. The first tick after `rst` deasserts advances from 1/1/`RESET_YEAR`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` mid-count with `RESET_YEAR`=1 → outputs 1/1/1, `leap_year`=0, all pulses 0, within the same cycle.
- **Leap-rule sweep:**
  - Load 2019-02-28, tick → 2019-03-01.
  - Load 2020-02-28, tick twice → 02-29, then 03-01, with `leap_year`=1.
  - 1900-02-28 + tick → 03-01.
  - 2000-02-28 + tick → 02-29.
- **Wrap:** load 2047-12-31, tick → 0001-01-01, `year_wrap`=1 for one cycle, `leap_year`=0. Load 2046-12-31, tick → 2047-01-01 with no `year_wrap`.
- **Invalid loads:** 2019-02-29, 2020-04-31, month 0, month 13, day 0 and year 0 each → `load_err` pulse, date unchanged, no `date_changed`.
- **Priority:** `load`=2020-06-15 together with `day_tick` → date 2020-06-15, not 06-16.
- **Full-year run:** from 2021-01-01, 364 ticks → 2021-12-31 and downstream day_of_year=365. From 2024-01-01, 365 ticks → 2024-12-31 and day_of_year=366.
